// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - op codes, FSM states and helpers for the memory access stage
package mem_access_pkg;

    localparam logic [1:0] MEM_NONE = 2'b00;
    localparam logic [1:0] MEM_LD   = 2'b01;
    localparam logic [1:0] MEM_ST   = 2'b10;
    localparam logic [1:0] MEM_RSV  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        REQ    = 2'b01,
        WAIT_R = 2'b10,
        DONE   = 2'b11
    } state_t;

    function automatic logic is_mem_op(input logic [1:0] op);
        return (op == MEM_LD) || (op == MEM_ST);
    endfunction

endpackage

// File: rtl/mem_access.sv
// rtl/mem_access.sv - memory access stage: one op in flight, data-memory handshake, writeback pulse
module mem_access
    import mem_access_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        MEM,
    input  logic [DATA_W-1:0] result,
    input  logic [DATA_W-1:0] wdata,
    input  logic [RD_W-1:0]   rd,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [RD_W-1:0]   wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              misalign
);

    state_t            state, state_nx;
    logic [1:0]        op_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] data_q;
    logic [RD_W-1:0]   rd_q;
    logic              mis_q;
    logic              accept;
    logic              mis_in;

    assign accept = in_valid && (state == IDLE);
    assign mis_in = is_mem_op(MEM) && (result[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            op_q    <= MEM_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            rd_q    <= '0;
            mis_q   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_q    <= MEM;
                addr_q  <= result;
                wdata_q <= wdata;
                data_q  <= result;
                rd_q    <= rd;
                mis_q   <= mis_in;
            end
            // data_q doubles as the load return buffer once the address is on the bus
            if ((state == WAIT_R) && dmem_rvalid) begin
                data_q <= dmem_rdata;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        in_ready   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        wb_valid   = 1'b0;
        wb_we      = 1'b0;
        wb_rd      = '0;
        wb_data    = '0;
        misalign   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nx = (is_mem_op(MEM) && !mis_in) ? REQ : DONE;
                end
            end
            REQ: begin
                dmem_req   = 1'b1;
                dmem_we    = (op_q == MEM_ST);
                dmem_addr  = addr_q;
                dmem_wdata = wdata_q;
                if (dmem_gnt) begin
                    state_nx = (op_q == MEM_ST) ? DONE : WAIT_R;
                end
            end
            WAIT_R: begin
                if (dmem_rvalid) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
                wb_valid = 1'b1;
                wb_rd    = rd_q;
                wb_data  = data_q;
                misalign = mis_q;
                // only pass-through and completed loads write the register file
                wb_we    = !mis_q && ((op_q == MEM_NONE) || (op_q == MEM_LD));
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - directed and randomized checks of mem_access against a transaction-level model
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  op = 2'b00;
    logic [31:0] result = '0;
    logic [31:0] wdata = '0;
    logic [4:0]  rd = '0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_gnt = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        wb_valid, wb_we, misalign;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int errors = 0;
    int checks = 0;

    mem_access #(.DATA_W(32), .RD_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .MEM(op), .result(result), .wdata(wdata), .rd(rd),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction; expectations come from the op-level rules:
    // REQ lasts gnt_wait+1 cycles, WAIT_R lasts rv_wait+1 cycles, writeback one cycle later.
    task automatic run_op(input logic [1:0] o, input logic [31:0] res, input logic [31:0] wd,
                          input logic [4:0] r, input int gnt_wait, input int rv_wait,
                          input logic [31:0] rdat);
        bit mis, aligned_mem, is_ld;
        int n_req, n_wait, lat;
        logic [31:0] exp_data;
        logic exp_we;
        mis = ((o == 2'b01) || (o == 2'b10)) && (res[1:0] != 2'b00);
        aligned_mem = ((o == 2'b01) || (o == 2'b10)) && !mis;
        is_ld = (o == 2'b01) && !mis;
        n_req = aligned_mem ? gnt_wait + 1 : 0;
        n_wait = is_ld ? rv_wait + 1 : 0;
        lat = 1 + n_req + n_wait;
        exp_we = (o == 2'b00) || is_ld;
        exp_data = is_ld ? rdat : res;

        @(negedge clk);
        chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1; op = o; result = res; wdata = wd; rd = r;
        @(negedge clk);
        in_valid = 1'b0; op = $urandom; result = $urandom; wdata = $urandom; rd = $urandom;
        for (int c = 1; c <= lat; c++) begin
            dmem_gnt = (c <= n_req) && (c == n_req);
            if (c <= n_req) dmem_rvalid = $urandom_range(0, 1);
            else dmem_rvalid = (c == n_req + n_wait) && (n_wait > 0);
            dmem_rdata = dmem_rvalid ? ((c > n_req) ? rdat : $urandom) : $urandom;
            #1;
            chk("dmem_req", {31'b0, dmem_req}, {31'b0, c <= n_req});
            if (c <= n_req) begin
                chk("dmem_addr", dmem_addr, res);
                chk("dmem_wdata", dmem_wdata, wd);
                chk("dmem_we", {31'b0, dmem_we}, {31'b0, o == 2'b10});
            end
            chk("in_ready_busy", {31'b0, in_ready}, 32'd0);
            chk("wb_valid", {31'b0, wb_valid}, {31'b0, c == lat});
            if (c == lat) begin
                chk("wb_we", {31'b0, wb_we}, {31'b0, exp_we});
                chk("wb_rd", {27'b0, wb_rd}, {27'b0, r});
                chk("misalign", {31'b0, misalign}, {31'b0, mis});
                if (!(aligned_mem && !is_ld) && !mis) chk("wb_data", wb_data, exp_data);
            end else begin
                chk("misalign_idle", {31'b0, misalign}, 32'd0);
            end
            @(negedge clk);
        end
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b1;
        #1;
        chk("wb_valid_after", {31'b0, wb_valid}, 32'd0);
        chk("dmem_req_after", {31'b0, dmem_req}, 32'd0);
        dmem_rvalid = 1'b0;
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
        chk("rst_dmem_we", {31'b0, dmem_we}, 32'd0);
        chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("rst_wb_we", {31'b0, wb_we}, 32'd0);
        chk("rst_misalign", {31'b0, misalign}, 32'd0);
        chk("rst_dmem_addr", dmem_addr, 32'd0);
        chk("rst_dmem_wdata", dmem_wdata, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_rd", {27'b0, wb_rd}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // directed cases
        run_op(2'b00, 32'h0000_1234, 32'h0, 5'd3, 0, 0, 32'h0);
        run_op(2'b10, 32'h0000_0100, 32'hDEAD_BEEF, 5'd7, 2, 0, 32'h0);
        run_op(2'b01, 32'h0000_0200, 32'h0, 5'd9, 0, 2, 32'hCAFE_F00D);
        run_op(2'b01, 32'h0000_0202, 32'h0, 5'd4, 0, 0, 32'h0);
        run_op(2'b10, 32'h0000_0301, 32'h1111_2222, 5'd5, 0, 0, 32'h0);
        run_op(2'b11, 32'h0000_5555, 32'h0, 5'd6, 0, 0, 32'h0);

        // reset in the middle of a load
        @(negedge clk);
        in_valid = 1'b1; op = 2'b01; result = 32'h0000_0400; rd = 5'd12;
        @(negedge clk);
        in_valid = 1'b0;
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("midrst_wb_valid", {31'b0, wb_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dmem_rvalid = 1'b1; dmem_rdata = 32'hBAD0_0000 + i;
            #1;
            chk("postrst_wb_valid", {31'b0, wb_valid}, 32'd0);
            chk("postrst_in_ready", {31'b0, in_ready}, 32'd1);
            @(negedge clk);
        end
        dmem_rvalid = 1'b0;
        #1;
        chk("postrst_wb_valid_end", {31'b0, wb_valid}, 32'd0);

        // back-to-back with in_valid held high
        @(negedge clk);
        in_valid = 1'b1; op = 2'b00; result = 32'h0000_00AA; rd = 5'd1;
        @(negedge clk);
        op = 2'b00; result = 32'h0000_00BB; rd = 5'd2;
        #1;
        chk("b2b_first_wb", {31'b0, wb_valid}, 32'd1);
        chk("b2b_first_data", wb_data, 32'h0000_00AA);
        chk("b2b_not_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        #1;
        chk("b2b_idle_ready", {31'b0, in_ready}, 32'd1);
        chk("b2b_idle_wb", {31'b0, wb_valid}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("b2b_second_wb", {31'b0, wb_valid}, 32'd1);
        chk("b2b_second_data", wb_data, 32'h0000_00BB);
        chk("b2b_second_rd", {27'b0, wb_rd}, 32'd2);

        // randomized operations
        for (int k = 0; k < 40; k++) begin
            logic [1:0]  ro;
            logic [31:0] rr;
            ro = 2'($urandom_range(0, 3));
            rr = $urandom;
            if ($urandom_range(0, 3) != 0) rr[1:0] = 2'b00;
            run_op(ro, rr, $urandom, 5'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
